// File: rtl/sift_ram_arbiter.sv
// Shares one single-port image-plane RAM between the feature writer (W) and readers R0..R2.
// Define SIFT_ARB_STATS_EN to add the stat_conflict / stat_starve counters.
module sift_ram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_gnt,
    input  logic [2:0]          rd_req,
    input  logic [3*ADDR_W-1:0] rd_addr,
    output logic [2:0]          rd_gnt,
    output logic [2:0]          rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
`ifdef SIFT_ARB_STATS_EN
    output logic [15:0]         stat_conflict,
    output logic [15:0]         stat_starve,
`endif
    input  logic [DATA_W-1:0]   ram_dout
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        starve_cnt;
    logic [1:0]        rr_ptr;
    logic [1:0]        rd_sel;
    logic [1:0]        cand;
    logic              rd_win;
    logic              any_rd;
    logic              force_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        issue_tag;
    logic [2:0]        tag_pipe [RAM_LAT];

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    assign any_rd   = |rd_req;
    assign force_rd = any_rd && (starve_cnt == STARVE_LIM);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        wr_gnt = wr_req && !force_rd;
        rd_gnt = 3'b000;
        rd_sel = 2'd0;
        rd_win = 1'b0;
        cand   = 2'd0;
        if (!wr_gnt && any_rd) begin
            // Round-robin search starts just after the last reader served.
            for (int k = 1; k <= 3; k++) begin
                cand = wrap3(3'(rr_ptr) + 3'(k));
                if (!rd_win && rd_req[cand]) begin
                    rd_win = 1'b1;
                    rd_sel = cand;
                end
            end
        end
        if (rd_win) rd_gnt = 3'b001 << rd_sel;
    end

    always_comb begin
        case (rd_sel)
            2'd1:    sel_addr = rd_addr[2*ADDR_W-1:ADDR_W];
            2'd2:    sel_addr = rd_addr[3*ADDR_W-1:2*ADDR_W];
            default: sel_addr = rd_addr[ADDR_W-1:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            starve_cnt <= '0;
            rr_ptr     <= 2'd2;
            issue_tag  <= '0;
        end else begin
            // NOTE: non-blocking, so every register samples this cycle's arbitration result.
            ram_we <= wr_gnt;
            if (wr_gnt) begin
                ram_addr <= wr_addr;
                ram_din  <= wr_data;
            end else if (rd_win) begin
                ram_addr <= sel_addr;
            end
            if (rd_win || !any_rd)
                starve_cnt <= '0;
            else if (wr_gnt && starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;
            if (rd_win) rr_ptr <= rd_sel;
            issue_tag <= rd_gnt;
        end
    end

    // NOTE: the tag pipe is a few flops, so it is reset to discard in-flight reads; RAM contents are not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign rd_valid = tag_pipe[RAM_LAT-1];
    assign rd_data  = ram_dout;

`ifdef SIFT_ARB_STATS_EN
    logic [2:0] req_cnt;
    assign req_cnt = 3'(wr_req) + 3'(rd_req[0]) + 3'(rd_req[1]) + 3'(rd_req[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conflict <= '0;
            stat_starve   <= '0;
        end else begin
            if (req_cnt >= 3'd2 && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
            if (force_rd && stat_starve != 16'hFFFF) stat_starve <= stat_starve + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sift_ram_arbiter.sv
// Scoreboard bench for sift_ram_arbiter: directed scenarios plus randomized requesters
// against a behavioural arbitration/RAM model. Works with or without SIFT_ARB_STATS_EN.
module tb_sift_ram_arbiter;
    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 8;
    localparam int RAM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_gnt;
    logic [2:0]          rd_req;
    logic [3*ADDR_W-1:0] rd_addr;
    logic [2:0]          rd_gnt;
    logic [2:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_din;
    logic [DATA_W-1:0]   ram_dout;
`ifdef SIFT_ARB_STATS_EN
    logic [15:0]         stat_conflict;
    logic [15:0]         stat_starve;
`endif

    sift_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
`ifdef SIFT_ARB_STATS_EN
        .stat_conflict(stat_conflict), .stat_starve(stat_starve),
`endif
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h3C;
    endfunction

    // Single-port RAM with RAM_LAT cycles from registered address to data.
    logic [7:0] ram_mem  [0:262143];
    bit         ram_seen [0:262143];
    logic [7:0] dly      [RAM_LAT];
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[int'(ram_addr)]  <= ram_din;
            ram_seen[int'(ram_addr)] <= 1'b1;
        end
        dly[0] <= ram_seen[int'(ram_addr)] ? ram_mem[int'(ram_addr)] : init_val(ram_addr);
        for (int i = 1; i < RAM_LAT; i++) dly[i] <= dly[i-1];
    end
    assign ram_dout = dly[RAM_LAT-1];

    typedef struct {
        logic [2:0] tag;
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    rd_exp_t    sb[$];
    rd_exp_t    mon_e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    // Behavioural model state
    logic [7:0]        m_mem [int];
    int                m_starve, m_rr, m_conflict, m_starve_ev;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_din;
    bit                g_w;
    int                g_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [ADDR_W-1:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : init_val(a);
    endfunction

    task automatic model_reset();
        m_starve = 0; m_rr = 2; m_conflict = 0; m_starve_ev = 0;
        m_we = 1'b0; m_addr = '0; m_din = '0;
        g_w = 1'b0; g_r = -1;
        sb.delete();
    endtask

    // Evaluate one cycle at mid-cycle: compare DUT, then advance the model.
    task automatic eval_cycle();
        logic [3:0]        exp_g;
        logic [2:0]        tag;
        logic [ADDR_W-1:0] a;
        int                win_r, nreq;
        bit                win_w, any_rd, forced;
        any_rd = (rd_req != 3'b000);
        forced = any_rd && (m_starve == STARVE_MAX);
        win_w  = wr_req && !forced;
        win_r  = -1;
        if (!win_w && any_rd)
            for (int k = 1; k <= 3; k++)
                if (win_r < 0 && rd_req[(m_rr + k) % 3]) win_r = (m_rr + k) % 3;
        exp_g = {win_w, win_r == 2, win_r == 1, win_r == 0};
        check("grant", {wr_gnt, rd_gnt}, exp_g);
        check("ram_we", ram_we, m_we);
        check("ram_addr", ram_addr, m_addr);
        if (m_we) check("ram_din", ram_din, m_din);
`ifdef SIFT_ARB_STATS_EN
        check("stat_conflict", stat_conflict, m_conflict);
        check("stat_starve", stat_starve, m_starve_ev);
`endif
        nreq = int'(wr_req) + $countones(rd_req);
        if (nreq >= 2 && m_conflict < 65535) m_conflict++;
        if (win_r >= 0 && forced && m_starve_ev < 65535) m_starve_ev++;
        m_we = win_w;
        if (win_w) begin
            m_addr = wr_addr;
            m_din  = wr_data;
            m_mem[int'(wr_addr)] = wr_data;
        end else if (win_r >= 0) begin
            a      = rd_addr[win_r*ADDR_W +: ADDR_W];
            m_addr = a;
            tag    = 3'b001 << win_r;
            sb.push_back('{tag: tag, data: m_rd(a), due: cyc + 1 + RAM_LAT});
        end
        if (win_r >= 0 || !any_rd) m_starve = 0;
        else if (win_w && m_starve < STARVE_MAX) m_starve++;
        if (win_r >= 0) m_rr = win_r;
        g_w = win_w;
        g_r = win_r;
        cyc++;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always begin
        @(posedge clk);
        #3;
        if (rd_valid != 3'b000) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", rd_valid, 3'b000);
            end else begin
                mon_e = sb.pop_front();
                check("rd_tag", rd_valid, mon_e.tag);
                check("rd_data", rd_data, mon_e.data);
                check("rd_latency", cyc, mon_e.due);
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("rd_valid_missing", rd_valid, mon_e.tag);
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step_expect(input string name, input logic [3:0] g);
        #1;
        check(name, {wr_gnt, rd_gnt}, g);
        step();
    endtask

    task automatic idle(input int n);
        wr_req = 1'b0;
        rd_req = 3'b000;
        repeat (n) step();
    endtask

    task automatic pulse_reset(input int ncyc);
        #1;
        rst    = 1'b1;
        wr_req = 1'b0;
        rd_req = 3'b000;
        model_reset();
        #1;
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_rd_valid", rd_valid, 3'b000);
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        return ($urandom_range(3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(31));
    endfunction

    // Requesters hold until granted; after a grant they may issue a new access.
    task automatic rand_update(input int wr_pct, input int rd_pct);
        if (g_w || !wr_req) begin
            wr_req = ($urandom_range(99) < wr_pct);
            if (wr_req) begin
                wr_addr = rand_addr();
                wr_data = DATA_W'($urandom);
            end
        end
        for (int r = 0; r < 3; r++) begin
            if (g_r == r || !rd_req[r]) begin
                rd_req[r] = ($urandom_range(99) < rd_pct);
                if (rd_req[r]) rd_addr[r*ADDR_W +: ADDR_W] = rand_addr();
            end
        end
    endtask

    logic [3:0] rr_seq     [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    logic [3:0] starve_seq [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b1000};

    initial begin
        rst = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = 3'b000; rd_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-stream: an R1 read granted just before reset must never return.
        rd_req = 3'b010;
        rd_addr[ADDR_W +: ADDR_W] = 18'h00123;
        step();
        pulse_reset(2);
        for (int i = 0; i < 12; i++) begin
            check("post_rst_no_valid", rd_valid, 3'b000);
            step();
        end

        // Single read of a freshly written word.
        wr_req = 1'b1; wr_addr = 18'h00C05; wr_data = 8'h5A;
        step();
        wr_req = 1'b0;
        rd_req = 3'b001;
        rd_addr[0 +: ADDR_W] = 18'h00C05;
        step_expect("single_rd_gnt", 4'b0001);
        idle(5);

        // Write beats a simultaneous reader, which is served next.
        wr_req = 1'b1; wr_addr = 18'h00100; wr_data = 8'h11;
        rd_req = 3'b010;
        rd_addr[ADDR_W +: ADDR_W] = 18'h00C05;
        step_expect("wr_prio_w", 4'b1000);
        wr_req = 1'b0;
        step_expect("wr_prio_r1", 4'b0010);
        idle(5);

        // Round-robin with all readers held.
        pulse_reset(1);
        rd_req = 3'b111;
        rd_addr = {18'h00003, 18'h00002, 18'h00001};
        for (int i = 0; i < 5; i++) step_expect("rr_seq", rr_seq[i]);
        idle(5);

        // Starvation: W held against R2.
        pulse_reset(1);
        wr_req = 1'b1; wr_addr = 18'h00200; wr_data = 8'hA5;
        rd_req = 3'b100;
        rd_addr[2*ADDR_W +: ADDR_W] = 18'h00200;
        for (int i = 0; i < 5; i++) step_expect("starve_seq", starve_seq[i]);
`ifdef SIFT_ARB_STATS_EN
        check("starve_stat_conflict", stat_conflict, 16'd5);
        check("starve_stat_starve", stat_starve, 16'd1);
`endif
        step_expect("starve_seq", starve_seq[5]);
        idle(6);

        // Randomized traffic at increasing write pressure.
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 600; i++) begin
                rand_update((p == 0) ? 30 : (p == 1) ? 70 : 95, 50);
                step();
            end
        idle(10);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sift_ram_arbiter.md
Name: sift_ram_arbiter

Overview:
Arbiter and sequencer for one single-port 8-bit image-plane RAM (gradient magnitude or direction, 2^18 words). It shares the RAM between four requesters:
- the feature-detection writer (requester W), which streams mag/dir results;
- three readers: canny edge detector (R0), descriptor calculator (R1) and EPP readout (R2).
It registers RAM address, write-enable and write-data, and returns read data to the winning reader with a one-hot valid tag. Sits between sift_feat/canny/sift_desc/EPP and the ram_mag*/ram_dir* instances.

Parameters:
ADDR_W, 18, RAM address width
DATA_W, 8, RAM data width
RAM_LAT, 1, RAM read latency in cycles from registered address to ram_dout (1..3)
STARVE_MAX, 15, consecutive cycles readers may lose to W before a reader is forced to win (1..255)

Ports:
clk  in  1  system clock (clk_50 or clk_100 domain of the RAM)
rst  in  1  asynchronous, active-high reset
wr_req  in  1  W requests a write this cycle
wr_addr  in  ADDR_W  W write address
wr_data  in  DATA_W  W write data
wr_gnt  out  1  W granted this cycle (combinational)
rd_req  in  3  per-reader request {R2,R1,R0}
rd_addr  in  3*ADDR_W  packed reader addresses, R0 in LSBs
rd_gnt  out  3  one-hot reader grant (combinational)
rd_valid  out  3  one-hot: rd_data belongs to this reader this cycle
rd_data  out  DATA_W  read data, shared by all readers
ram_we  out  1  registered RAM write enable, high = write
ram_addr  out  ADDR_W  registered RAM address
ram_din  out  DATA_W  registered RAM write data
ram_dout  in  DATA_W  RAM read data

Behaviour:
- At most one grant per cycle across wr_gnt and rd_gnt. No request means no grant.
- Requesters hold req and address until granted. If req is still high in the cycle after a grant, it is a new access.
- Priority: W beats readers unless starve_cnt == STARVE_MAX. In that case the reader wins and W waits.
- Readers are arbitrated round-robin. rr_ptr holds the last-granted reader; search starts at rr_ptr+1 mod 3. rr_ptr updates only on a reader grant.
- starve_cnt (8 bit):
  - increments when any rd_req is high and W is granted;
  - clears on any reader grant, or when rd_req == 0;
  - saturates at STARVE_MAX.
- Grant in cycle t: at edge t+1, ram_addr/ram_we/ram_din load the winner's values (ram_we=1 only for W).
- No grant in cycle t: ram_we=0 at t+1 and ram_addr holds its last value.
- Read tag: a RAM_LAT-deep shift register of 3-bit one-hot tags. A reader grant at t produces rd_valid at cycle t+1+RAM_LAT, with rd_data = ram_dout passed through combinationally.
- Back-to-back reads are fully pipelined, 1 per cycle. A write interleaved between reads does not disturb the tags.
- Reset (async, any time): ram_we=0, ram_addr=0, ram_din=0, all tags=0 (rd_valid=0), starve_cnt=0, rr_ptr=2 so R0 is searched first. In-flight reads are discarded and no rd_valid is produced after reset deassertion for pre-reset grants.
- Out-of-range inputs (address width mismatch) are not checked; addresses are passed modulo 2^ADDR_W.

Optional Feature:
SIFT_ARB_STATS_EN
- Defined: adds output ports stat_conflict (16 bit) and stat_starve (16 bit), both saturating at 16'hFFFF and cleared by rst.
  - stat_conflict increments each cycle two or more requests (W + readers) are active.
  - stat_starve increments each time a reader wins because starve_cnt == STARVE_MAX.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset mid-stream: R1 granted at cycle 10 (RAM_LAT=1), rst pulsed at cycle 11 -> rd_valid stays 3'b000 through cycle 20; ram_we=0, ram_addr=0 during reset.
2. Single read: R0 requests addr 18'h00C05 at cycle 5, ram returns 8'h5A -> rd_gnt=3'b001 at cycle 5, ram_addr=18'h00C05 at cycle 6, rd_valid=3'b001 with rd_data=8'h5A at cycle 7.
3. Write priority: wr_req and rd_req=3'b010 both high at cycle 3 -> wr_gnt=1 at 3, ram_we=1 at 4; R1 granted at 4, rd_valid=3'b010 at 6.
4. Round-robin: rd_req=3'b111 held, no writes -> grants R0,R1,R2,R0,R1 on consecutive cycles; rd_valid follows each by 2 cycles with matching one-hot tags.
5. Starvation: STARVE_MAX=4, wr_req held high, rd_req=3'b100 held -> W granted 4 cycles, R2 granted on the 5th, then W again; with SIFT_ARB_STATS_EN, stat_starve=1 and stat_conflict=5 after those 5 cycles.
6. Pipeline at RAM_LAT=3: reads R0,R1,R2 granted at cycles 0,1,2 -> rd_valid 3'b001,3'b010,3'b100 at cycles 4,5,6.
